alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode/issue stage sitting directly upstream of the integer ALU in the RISC-V core. It accepts one RV32I OP or OP-IMM instruction at a time over a valid/ready handshake and holds the 32×32 architectural register file. It drives the ALU operand and opcode ports, captures the ALU result, writes it back, and reports retirement or an illegal instruction.

## Interface
- CLEAR_ON_RESET, 1: when 1, reset zeroes all 32 registers; when 0, reset leaves register contents untouched.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  upstream has an instruction on `instr`.
- instr_ready  out  1  stage can accept; high only in IDLE.
- instr  in  32  RV32I instruction word.
- alu_a  out  32  ALU operand A (registered).
- alu_b  out  32  ALU operand B (registered).
- alu_op  out  3  ALU operation; equals instruction funct3 (registered).
- alu_result  in  32  combinational ALU output for current alu_a/alu_b/alu_op.
- retire_valid  out  1  one-cycle pulse; instruction finished.
- retire_illegal  out  1  qualifies retire_valid; instruction rejected, no writeback.
- retire_rd  out  5  destination index of the retired instruction.
- retire_data  out  32  value computed for rd (0 when illegal).
- dbg_addr  in  5  debug register-file read index.
- dbg_data  out  32  combinational read of register dbg_addr; x0 reads 0.

## Operation
- States: IDLE, DECODE, EXEC, RETIRE.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE. instr_valid outside IDLE is ignored; upstream holds.
- DECODE: read rs1=instr[19:15]; rs2=instr[24:20]; x0 reads 0. Legality rules:
  - opcode 0010011 (OP-IMM): B = sign-extended instr[31:20]. funct3 001 or 101 additionally requires instr[31:25]=0000000 (SRAI illegal).
  - opcode 0110011 (OP): B = reg[rs2]; requires instr[31:25]=0000000 (SUB, SRA and M-extension are illegal).
  - Any other opcode is illegal.
  - Legal: load alu_a=reg[rs1], alu_b=B, alu_op=instr[14:12]; go to EXEC.
  - Illegal: go to RETIRE with illegal flag set. alu_* are not updated.
- EXEC: alu_result is sampled at the end of the cycle. Write reg[rd]=alu_result unless rd=0. Capture retire_data=alu_result and retire_rd=instr[11:7]. Go to RETIRE.
- RETIRE: retire_valid=1 for exactly one cycle. retire_illegal=1 iff illegal. Go to IDLE.
- Immediate shifts: the ALU uses B[4:0] = instr[24:20]; no extra masking is done here.
- rd=x0: retire_data still reports the computed value; x0 stays 0.
- Register file: 1 write port, 2 internal read ports, 1 debug read port. A write becomes visible the cycle after EXEC; dbg_data returns the old value during the write cycle.

## Timing
- Handshake accepted in cycle T.
  - Legal instruction: DECODE in T+1, EXEC in T+2, retire_valid in T+3, instr_ready high again in T+4.
  - Illegal instruction: DECODE in T+1, retire_valid in T+2, instr_ready high in T+3.
- Throughput: one legal instruction per 4 cycles; no pipelining and no forwarding is needed.
- Reset values: state IDLE, instr_ready=1, alu_a=alu_b=0, alu_op=0, retire_valid=0, retire_illegal=0, retire_rd=0, retire_data=0. Registers are 0 when CLEAR_ON_RESET=1.
- Reset mid-operation, in any state: aborts immediately. No register write occurs, no retire pulse is produced, and the stage returns to IDLE. An instruction in EXEC when rst rises is not written back.
- retire_illegal is 0 whenever retire_valid is 0.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) accepted at T → retire_valid at T+3, retire_rd=1, retire_data=5; dbg x1=5 from T+3 on; instr_ready=1 at T+4.
- ADDI x2,x0,-1 (0xFFF00113), then SLTU x3,x1,x2 (0x0020B1B3), then SLT x4,x1,x2 (0x0020A233) → x2=0xFFFFFFFF, x3=1, x4=0; alu_op observed as 3 and 2 during the respective EXEC cycles.
- SUB x5,x1,x2 (0x402082B3) and word 0x00000073 → each gives retire_valid with retire_illegal=1 at T+2, retire_data=0; x5 remains 0; alu_* unchanged.
- ADDI x0,x0,7 (0x00700013) → retire_rd=0, retire_data=7, dbg x0=0.
- SLLI x6,x1,4 (0x00409313) → x6=0x50. SRLI x7,x2,28 (0x01C15393) → x7=0xF. SRAI word 0x41C15393 → illegal.
- Assert rst during EXEC of ADDI x8,x0,9 → no retire pulse; after release instr_ready=1 and x8=0 (CLEAR_ON_RESET=1). Also check with CLEAR_ON_RESET=0 that x1 retains its prior value.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//
// Decode/issue stage in front of the integer ALU. Accepts one RV32I OP or
// OP-IMM instruction at a time, reads operands from the 32x32 register file,
// drives the ALU, writes the result back and reports retirement.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   instr_valid     upstream has an instruction on instr
//   instr_ready     high only while idle
//   instr           RV32I instruction word
//   alu_a, alu_b    registered ALU operands
//   alu_op          registered ALU operation (instruction funct3)
//   alu_result      combinational ALU output for the current operands
//   retire_valid    one-cycle pulse when an instruction finishes
//   retire_illegal  qualifies retire_valid: instruction rejected, no writeback
//   retire_rd       destination index of the retired instruction
//   retire_data     value computed for rd (0 when illegal)
//   dbg_addr        debug read index
//   dbg_data        combinational read of dbg_addr (x0 reads 0)
module alu_issue_stage #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        retire_valid,
    output logic        retire_illegal,
    output logic [4:0]  retire_rd,
    output logic [31:0] retire_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcOp    = 7'b0110011;

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StRetire} state_e;

    state_e      state_q;
    logic [31:0] instr_q;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [2:0]  alu_op_q;
    logic        retire_valid_q;
    logic        retire_illegal_q;
    logic [4:0]  retire_rd_q;
    logic [31:0] retire_data_q;

    logic [31:0] regs [32];

    // Decode of the latched instruction
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] operand_b;
    logic        legal;
    logic        rf_we;

    always_comb begin
        opcode    = instr_q[6:0];
        funct3    = instr_q[14:12];
        funct7    = instr_q[31:25];
        rs1       = instr_q[19:15];
        rs2       = instr_q[24:20];
        rd        = instr_q[11:7];
        rs1_val   = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
        rs2_val   = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
        imm       = {{20{instr_q[31]}}, instr_q[31:20]};
        operand_b = rs2_val;
        legal     = 1'b0;
        if (opcode == OpcOpImm) begin
            operand_b = imm;
            // Shift-immediates carry funct7 in imm[11:5]; only the zero form is accepted
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
                legal = (funct7 == 7'b0000000);
            end else begin
                legal = 1'b1;
            end
        end else if (opcode == OpcOp) begin
            legal = (funct7 == 7'b0000000);
        end
    end

    // Gated with rst so an instruction caught in EXEC by reset never writes back
    assign rf_we = (state_q == StExec) && (rd != 5'd0) && !rst;

    if (CLEAR_ON_RESET) begin : g_rf_clear
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) begin
                    regs[i] <= '0;
                end
            end else if (rf_we) begin
                regs[rd] <= alu_result;
            end
        end
    end else begin : g_rf_keep
        always_ff @(posedge clk) begin
            if (rf_we) begin
                regs[rd] <= alu_result;
            end
        end
    end

    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            instr_q          <= '0;
            alu_a_q          <= '0;
            alu_b_q          <= '0;
            alu_op_q         <= '0;
            retire_valid_q   <= 1'b0;
            retire_illegal_q <= 1'b0;
            retire_rd_q      <= '0;
            retire_data_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    if (legal) begin
                        alu_a_q  <= rs1_val;
                        alu_b_q  <= operand_b;
                        alu_op_q <= funct3;
                        state_q  <= StExec;
                    end else begin
                        retire_valid_q   <= 1'b1;
                        retire_illegal_q <= 1'b1;
                        retire_rd_q      <= rd;
                        retire_data_q    <= '0;
                        state_q          <= StRetire;
                    end
                end
                StExec: begin
                    retire_valid_q   <= 1'b1;
                    retire_illegal_q <= 1'b0;
                    retire_rd_q      <= rd;
                    retire_data_q    <= alu_result;
                    state_q          <= StRetire;
                end
                StRetire: begin
                    retire_valid_q   <= 1'b0;
                    retire_illegal_q <= 1'b0;
                    state_q          <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign instr_ready    = (state_q == StIdle);
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_op         = alu_op_q;
    assign retire_valid   = retire_valid_q;
    assign retire_illegal = retire_illegal_q;
    assign retire_rd      = retire_rd_q;
    assign retire_data    = retire_data_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a clearing instance and a non-clearing instance
// share stimulus; each is paired with a behavioural ALU.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic [4:0]  dbg_addr;

    logic        ready0, rv0, ri0, ready1, rv1, ri1;
    logic [31:0] a0, b0, res0, rdata0, dbg0, a1, b1, res1, rdata1, dbg1;
    logic [2:0]  op0, op1;
    logic [4:0]  rd0, rd1;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] alu_model(logic [31:0] a, logic [31:0] b, logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    assign res0 = alu_model(a0, b0, op0);
    assign res1 = alu_model(a1, b1, op1);

    alu_issue_stage #(.CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(ready0), .instr(instr),
        .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_result(res0), .retire_valid(rv0),
        .retire_illegal(ri0), .retire_rd(rd0), .retire_data(rdata0), .dbg_addr(dbg_addr),
        .dbg_data(dbg0)
    );

    alu_issue_stage #(.CLEAR_ON_RESET(1'b0)) dut_keep (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(ready1), .instr(instr),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_result(res1), .retire_valid(rv1),
        .retire_illegal(ri1), .retire_rd(rd1), .retire_data(rdata1), .dbg_addr(dbg_addr),
        .dbg_data(dbg1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        bit          illegal;
        logic [31:0] data;
    } vec_t;

    vec_t        vecs [14];
    logic [31:0] shadow [32];

    task automatic issue(input vec_t v);
        logic [31:0] a_before, b_before;
        logic [2:0]  op_before;
        logic [4:0]  rd;
        int          lat;
        rd = v.instr[11:7];
        @(negedge clk);
        chk({v.name, " ready_before"}, 32'(ready0), 32'd1);
        a_before    = a0;
        b_before    = b0;
        op_before   = op0;
        instr       = v.instr;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = '0;
        lat = 0;
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            @(negedge clk);
            if (rv0) begin
                lat = k;
            end else begin
                chk({v.name, " illegal_without_valid"}, 32'(ri0), 32'd0);
                if (k == 2 && !v.illegal) begin
                    chk({v.name, " alu_op_exec"}, 32'(op0), 32'(v.instr[14:12]));
                    dbg_addr = rd;
                    #1;
                    chk({v.name, " dbg_old_during_write"}, dbg0, shadow[rd]);
                end
            end
        end
        chk({v.name, " latency"}, 32'(lat), v.illegal ? 32'd2 : 32'd3);
        if (lat != 0) begin
            chk({v.name, " retire_illegal"}, 32'(ri0), 32'(v.illegal));
            chk({v.name, " retire_data"}, rdata0, v.data);
            chk({v.name, " retire_data_keep"}, rdata1, v.data);
            if (!v.illegal) begin
                chk({v.name, " retire_rd"}, 32'(rd0), 32'(rd));
                if (rd != 5'd0) shadow[rd] = v.data;
            end else begin
                chk({v.name, " alu_a_held"}, a0, a_before);
                chk({v.name, " alu_b_held"}, b0, b_before);
                chk({v.name, " alu_op_held"}, 32'(op0), 32'(op_before));
            end
            dbg_addr = rd;
            #1;
            chk({v.name, " dbg_rd"}, dbg0, shadow[rd]);
        end
        @(negedge clk);
        chk({v.name, " ready_after"}, 32'(ready0), 32'd1);
        chk({v.name, " single_pulse"}, 32'(rv0), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"addi_x1_5",   32'h00500093, 1'b0, 32'h00000005};
        vecs[1]  = '{"addi_x2_m1",  32'hFFF00113, 1'b0, 32'hFFFFFFFF};
        vecs[2]  = '{"sltu_x3",     32'h0020B1B3, 1'b0, 32'h00000001};
        vecs[3]  = '{"slt_x4",      32'h0020A233, 1'b0, 32'h00000000};
        vecs[4]  = '{"sub_illegal", 32'h402082B3, 1'b1, 32'h00000000};
        vecs[5]  = '{"ecall_illeg", 32'h00000073, 1'b1, 32'h00000000};
        vecs[6]  = '{"addi_x0_7",   32'h00700013, 1'b0, 32'h00000007};
        vecs[7]  = '{"slli_x6",     32'h00409313, 1'b0, 32'h00000050};
        vecs[8]  = '{"srli_x7",     32'h01C15393, 1'b0, 32'h0000000F};
        vecs[9]  = '{"srai_illeg",  32'h41C15393, 1'b1, 32'h00000000};
        vecs[10] = '{"ori_x9",      32'h0300E493, 1'b0, 32'h00000035};
        vecs[11] = '{"add_x10",     32'h00608533, 1'b0, 32'h00000055};
        vecs[12] = '{"xori_x11",    32'h00F14593, 1'b0, 32'hFFFFFFF0};
        vecs[13] = '{"addi_x8_9",   32'h00900413, 1'b0, 32'h00000009};
        for (int i = 0; i < 32; i++) shadow[i] = '0;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset instr_ready", 32'(ready0), 32'd1);
        chk("reset alu_a", a0, 32'd0);
        chk("reset alu_b", b0, 32'd0);
        chk("reset alu_op", 32'(op0), 32'd0);
        chk("reset retire_valid", 32'(rv0), 32'd0);
        chk("reset retire_illegal", 32'(ri0), 32'd0);
        chk("reset retire_rd", 32'(rd0), 32'd0);
        chk("reset retire_data", rdata0, 32'd0);
        dbg_addr = 5'd1;
        #1;
        chk("reset x1", dbg0, 32'd0);

        for (int i = 0; i < 13; i++) issue(vecs[i]);

        // Reset during EXEC of ADDI x8,x0,9 must abort with no writeback or pulse
        @(negedge clk);
        instr       = 32'h00900413;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = '0;
        @(negedge clk);
        @(negedge clk);
        chk("abort in_exec alu_op", 32'(op0), 32'd0);
        chk("abort in_exec alu_b", b0, 32'd9);
        rst = 1'b1;
        #1;
        chk("abort immediate ready", 32'(ready0), 32'd1);
        chk("abort no pulse", 32'(rv0), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort quiet retire", 32'(rv0 | rv1), 32'd0);
            chk("abort ready", 32'(ready0), 32'd1);
        end
        chk("abort alu_a", a0, 32'd0);
        chk("abort retire_data", rdata0, 32'd0);
        chk("abort retire_rd", 32'(rd0), 32'd0);
        dbg_addr = 5'd8;
        #1;
        chk("abort x8 not written", dbg0, 32'd0);
        dbg_addr = 5'd1;
        #1;
        chk("clear x1 cleared", dbg0, 32'd0);
        chk("keep x1 retained", dbg1, 32'd5);
        dbg_addr = 5'd11;
        #1;
        chk("keep x11 retained", dbg1, 32'hFFFFFFF0);

        for (int i = 0; i < 32; i++) shadow[i] = '0;
        issue(vecs[13]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
